mem_write_checker: RTL and testbench

//  Parametrised self-checking monitor on the CPU data-memory write port. Compares each
//  new store against a loadable expected-result table, counts mismatches and run time,
//  and raises finish on completion or timeout. Replaces per-program hardcoded checkers;
//  one instance serves every test program via the table load port.

---
 rtl/mem_write_checker.sv | 127 ++++++++++++
 tb/tb_mem_write_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// Store-port monitor: checks each new store against a loadable expected table.
// It counts mismatches and run cycles, and ends in PASS or TIMEOUT.
module mem_write_checker #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 30,
  parameter int CHECK_NUM = 13,
  parameter int BASE_ADDR = 0,
  parameter int IN_ORDER  = 1,
  parameter int TIMEOUT   = 65535,
  parameter int ERR_W     = 8,
  parameter int DUR_W     = 16,
  localparam int IDX_W    = (CHECK_NUM > 1) ? $clog2(CHECK_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_wen,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  output logic [ERR_W-1:0]  error_num,
  output logic [DUR_W-1:0]  duration,
  output logic [6:0]        checked_cnt,
  output logic              finish,
  output logic              pass,
  output logic              timed_out
);
  typedef enum logic [1:0] {S_RUN = 2'd0, S_PASS = 2'd1, S_TIMEOUT = 2'd2} state_t;

  localparam int                DEPTH   = 1 << IDX_W;
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] NUM_A   = ADDR_W'(CHECK_NUM);
  localparam logic [IDX_W:0]    NUM_I   = (IDX_W+1)'(CHECK_NUM);
  localparam logic [6:0]        NUM_C   = 7'(CHECK_NUM);
  localparam logic [DUR_W-1:0]  TO_LAST = DUR_W'(TIMEOUT - 1);

  // Table is padded to a power of two so any idx read is in range.
  logic [DATA_W-1:0] tbl [DEPTH];
  logic [DEPTH-1:0]  done;
  logic              wen_q;
  state_t            state, state_nxt;

  logic [ADDR_W-1:0] offs;
  logic [IDX_W-1:0]  idx;
  logic              hit, accept, check, mismatch;
  logic [6:0]        cnt_nxt;
  logic [ERR_W-1:0]  err_nxt;
  logic [DUR_W-1:0]  dur_nxt;
  logic              finish_nxt, pass_nxt, tmo_nxt;

  // Negative offsets wrap to large unsigned values and miss.
  always_comb begin
    offs     = addr - BASE_A;
    idx      = offs[IDX_W-1:0];
    hit      = offs < NUM_A;
    accept   = wen && !wen_q && (state == S_RUN);
    check    = 1'b0;
    if (accept && hit)
      check = (IN_ORDER != 0) ? (7'(idx) == checked_cnt) : !done[idx];
    mismatch = check && (data != tbl[idx]);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = checked_cnt;
    err_nxt   = error_num;
    dur_nxt   = duration;
    case (state)
      S_RUN: begin
        dur_nxt = duration + 1'b1;
        if (check) cnt_nxt = checked_cnt + 1'b1;
        if (mismatch && error_num != '1) err_nxt = error_num + 1'b1;
        // A final check landing on the last cycle beats the timeout.
        if (checked_cnt == NUM_C)
          state_nxt = S_PASS;
        else if (duration == TO_LAST && cnt_nxt != NUM_C)
          state_nxt = S_TIMEOUT;
      end
      default: ;
    endcase
    finish_nxt = (state_nxt != S_RUN);
    tmo_nxt    = (state_nxt == S_TIMEOUT);
    pass_nxt   = (state_nxt == S_PASS) && (err_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_RUN;
      wen_q       <= 1'b0;
      done        <= '0;
      error_num   <= '0;
      duration    <= '0;
      checked_cnt <= '0;
      finish      <= 1'b0;
      pass        <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      state       <= state_nxt;
      wen_q       <= wen;
      error_num   <= err_nxt;
      duration    <= dur_nxt;
      checked_cnt <= cnt_nxt;
      finish      <= finish_nxt;
      pass        <= pass_nxt;
      timed_out   <= tmo_nxt;
      if (check) done[idx] <= 1'b1;
`ifdef SIM
      if (check)
        $display("%s: idx=%0d data=%h expected=%h", mismatch ? "Error" : "Correct",
                 idx, data, tbl[idx]);
      if (state == S_RUN && state_nxt != S_RUN)
        $display("checker done: %s errors=%0d checked=%0d cycles=%0d",
                 (state_nxt == S_PASS) ? "PASS" : "TIMEOUT", err_nxt, cnt_nxt, dur_nxt);
`endif
    end
  end

  // Check reads the table combinationally, so a same-edge load is seen only afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) tbl[k] <= '0;
    end else if (exp_wen && ({1'b0, exp_idx} < NUM_I)) begin
      tbl[exp_idx] <= exp_data;
    end
  end
endmodule

// File: tb/tb_mem_write_checker.sv
// Random + directed bench for mem_write_checker: one in-order and one any-order
// instance share stimulus and are compared against a behavioural model each cycle.
module tb_mem_write_checker;
  localparam int N = 13, BASE = 16, TO = 400, DW = 32, AW = 30, IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          exp_wen = 1'b0;
  logic [IW-1:0] exp_idx = '0;
  logic [DW-1:0] exp_data = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic          wen = 1'b0;

  logic [7:0]  err0;
  logic [1:0]  err1;
  logic [15:0] dur0, dur1;
  logic [6:0]  cc0, cc1;
  logic        fin0, fin1, pas0, pas1, tmo0, tmo1;

  mem_write_checker #(.DATA_W(DW), .ADDR_W(AW), .CHECK_NUM(N), .BASE_ADDR(BASE),
    .IN_ORDER(1), .TIMEOUT(TO), .ERR_W(8), .DUR_W(16)) u_ord (
    .clk(clk), .rst(rst), .exp_wen(exp_wen), .exp_idx(exp_idx), .exp_data(exp_data),
    .addr(addr), .data(data), .wen(wen), .error_num(err0), .duration(dur0),
    .checked_cnt(cc0), .finish(fin0), .pass(pas0), .timed_out(tmo0));

  mem_write_checker #(.DATA_W(DW), .ADDR_W(AW), .CHECK_NUM(N), .BASE_ADDR(BASE),
    .IN_ORDER(0), .TIMEOUT(TO), .ERR_W(2), .DUR_W(16)) u_any (
    .clk(clk), .rst(rst), .exp_wen(exp_wen), .exp_idx(exp_idx), .exp_data(exp_data),
    .addr(addr), .data(data), .wen(wen), .error_num(err1), .duration(dur1),
    .checked_cnt(cc1), .finish(fin1), .pass(pas1), .timed_out(tmo1));

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-instance expected table, seen-set and counters.
  bit [DW-1:0] m_tbl [2][N];
  bit          m_done [2][N];
  int          m_cnt [2], m_err [2], m_dur [2];
  bit          m_fin [2], m_tmo [2];
  bit          m_wq;
  int          m_emax [2] = '{255, 3};
  bit          m_ord [2]  = '{1'b1, 1'b0};
  bit [DW-1:0] ref_val [N];

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < N; k++) begin m_tbl[i][k] = '0; m_done[i][k] = 1'b0; end
      m_cnt[i] = 0; m_err[i] = 0; m_dur[i] = 0; m_fin[i] = 1'b0; m_tmo[i] = 1'b0;
    end
    for (int k = 0; k < N; k++) ref_val[k] = '0;
    m_wq = 1'b0;
  endfunction

  function automatic void m_step();
    int idx = int'(addr) - BASE;
    bit hit = (idx >= 0) && (idx < N);
    bit acc = wen && !m_wq;
    for (int i = 0; i < 2; i++) begin
      if (!m_fin[i]) begin
        bit chk = 1'b0;
        int oc = m_cnt[i];
        int od = m_dur[i];
        if (acc && hit) chk = m_ord[i] ? (idx == m_cnt[i]) : !m_done[i][idx];
        if (chk) begin
          if (data != m_tbl[i][idx] && m_err[i] < m_emax[i]) m_err[i]++;
          m_cnt[i]++;
          m_done[i][idx] = 1'b1;
        end
        m_dur[i]++;
        if (oc == N) m_fin[i] = 1'b1;
        else if (od == TO - 1 && m_cnt[i] != N) begin m_fin[i] = 1'b1; m_tmo[i] = 1'b1; end
      end
    end
    if (exp_wen && int'(exp_idx) < N)
      for (int i = 0; i < 2; i++) m_tbl[i][exp_idx] = exp_data;
    m_wq = wen;
  endfunction

  task automatic compare();
    check("err0", err0, m_err[0]);   check("err1", err1, m_err[1]);
    check("dur0", dur0, m_dur[0]);   check("dur1", dur1, m_dur[1]);
    check("cnt0", cc0, m_cnt[0]);    check("cnt1", cc1, m_cnt[1]);
    check("fin0", fin0, m_fin[0]);   check("fin1", fin1, m_fin[1]);
    check("tmo0", tmo0, m_tmo[0]);   check("tmo1", tmo1, m_tmo[1]);
    check("pass0", pas0, m_fin[0] && !m_tmo[0] && m_err[0] == 0);
    check("pass1", pas1, m_fin[1] && !m_tmo[1] && m_err[1] == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) m_step();
    #1 compare();
  endtask

  task automatic do_reset();
    rst = 1'b0; wen = 1'b0; exp_wen = 1'b0;
    m_reset();
    #1 compare();
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic load_table();
    exp_wen = 1'b1;
    for (int k = 0; k < N; k++) begin
      exp_idx = IW'(k); exp_data = $urandom; ref_val[k] = exp_data;
      tick();
    end
    exp_idx = IW'(14); exp_data = $urandom;   // out-of-range index, must be dropped
    tick();
    exp_wen = 1'b0;
  endtask

  task automatic store(input int a, input logic [DW-1:0] d, input int hold);
    addr = AW'(a); data = d; wen = 1'b1;
    repeat (hold) tick();
    wen = 1'b0;
    tick();
  endtask

  task automatic wait_finish(input int budget);
    int c = 0;
    while (!(m_fin[0] && m_fin[1]) && c < budget) begin tick(); c++; end
    check("finish_budget", m_fin[0] && m_fin[1], 1);
  endtask

  int order [14] = '{12, 0, 12, 5, 3, 9, 1, 7, 11, 2, 8, 4, 10, 6};

  initial begin
    logic [15:0] dsnap;
    m_reset();
    tick(); tick();
    check("rst_fin", fin0, 0);
    rst = 1'b1;

    // In-order run, all correct; entry 3 held over stall cycles.
    load_table();
    for (int k = 0; k < N - 1; k++) begin
      store(BASE + k, ref_val[k], (k == 3) ? 4 : 1);
      if (k == 3) check("held_once", cc0, 4);
    end
    addr = AW'(BASE + N - 1); data = ref_val[N-1]; wen = 1'b1;
    tick();
    check("last_cnt", cc0, N);
    check("last_nofin", fin0, 0);
    wen = 1'b0;
    tick();
    check("pass_fin", fin0, 1);
    check("pass_ord", pas0, 1);
    check("pass_any", pas1, 1);
    dsnap = dur0;
    store(BASE, 0, 1); store(BASE + 1, 0, 2);
    check("frozen_dur", dur0, dsnap);

    // Out-of-order address ignored in order mode, one bad value, then random traffic.
    do_reset();
    load_table();
    store(BASE + 5, ref_val[5], 1);
    check("ooo_ignored", cc0, 0);
    store(BASE, ref_val[0], 1);
    store(BASE + 1, ref_val[1], 1);
    store(BASE + 2, ref_val[2] + 1, 1);
    check("bad_val", err0, 1);
    for (int it = 0; it < 500 && !(m_fin[0] && m_fin[1]); it++) begin
      int a = BASE - 2 + int'($urandom_range(0, 16));
      int ix = a - BASE;
      logic [DW-1:0] d = (ix >= 0 && ix < N) ? ref_val[ix] : $urandom;
      if ($urandom_range(0, 7) == 0) d = d ^ 32'h1;
      if ($urandom_range(0, 7) == 0) begin
        exp_wen = 1'b1; exp_idx = IW'($urandom_range(0, 15)); exp_data = $urandom;
        if (int'(exp_idx) < N) ref_val[exp_idx] = exp_data;
      end
      addr = AW'(a); data = d; wen = 1'b1;
      tick();
      exp_wen = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      wen = 1'b0;
      repeat ($urandom_range(1, 2)) tick();
    end
    wait_finish(TO);
    check("bad_nopass", pas0, 0);

    // Shuffled order with a duplicate, all values wrong.
    do_reset();
    load_table();
    for (int k = 0; k < 14; k++) store(BASE + order[k], ref_val[order[k]] + 1, 1);
    tick();
    check("any_cnt", cc1, N);
    check("any_sat", err1, 3);
    check("any_fin", fin1, 1);
    check("any_nopass", pas1, 0);
    check("ord_partial", cc0, 3);
    wait_finish(TO);
    check("to_flag", tmo0, 1);
    check("to_dur", dur0, TO);
    check("to_nopass", pas0, 0);
    store(BASE + 3, ref_val[3], 1);
    tick();
    check("to_frozen", dur0, TO);

    // Reset mid-run clears the table too.
    do_reset();
    load_table();
    store(BASE, ref_val[0] + 7, 1);
    store(BASE + 1, ref_val[1], 1);
    do_reset();
    check("mid_rst_err", err0, 0);
    store(BASE, 0, 1);
    store(BASE + 1, 5, 1);
    check("tbl_cleared", err0, 1);
    check("tbl_cnt", cc0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
